// File: rtl/alu_pkg.sv
// Shared constants for the ALU control path: control codes, opcodes,
// main-control ALU classes and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_NOT = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;
  localparam logic [1:0] ALUOP_BAD   = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {alu_op, opcode} -> ALU control code table.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter int ALUOP_W  = 2,
  parameter int OPCODE_W = 4,
  parameter int CTRL_W   = 4
) (
  input  logic [ALUOP_W-1:0]  alu_op,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CTRL_W-1:0]   code,
  output logic                multi_cycle,
  output logic                illegal
);

  logic [3:0] c;

  always_comb begin
    c           = ALU_ADD;
    multi_cycle = 1'b0;
    illegal     = 1'b0;
    if (alu_op == ALUOP_W'(ALUOP_SUB)) begin
      c = ALU_SUB;
    end else if (alu_op == ALUOP_W'(ALUOP_ADD)) begin
      c = ALU_ADD;
    end else if (alu_op == ALUOP_W'(ALUOP_RTYPE)) begin
      case (opcode)
        OPCODE_W'(OP_ADD), OPCODE_W'(OP_ADDI): c = ALU_ADD;
        OPCODE_W'(OP_SUB):                     c = ALU_SUB;
        OPCODE_W'(OP_NOT):                     c = ALU_NOT;
        OPCODE_W'(OP_SLL):                     c = ALU_SLL;
        OPCODE_W'(OP_SRL):                     c = ALU_SRL;
        OPCODE_W'(OP_AND):                     c = ALU_AND;
        OPCODE_W'(OP_OR):                      c = ALU_OR;
        OPCODE_W'(OP_MUL): begin
          c           = ALU_MUL;
          multi_cycle = 1'b1;
        end
        OPCODE_W'(OP_XOR):                     c = ALU_XOR;
        default:                               illegal = 1'b1;
      endcase
    end else begin
      illegal = 1'b1;
    end
  end

  assign code = CTRL_W'(c);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control sequencer: decodes ops with valid/ready on both
// sides and stretches MUL over MUL_LAT cycles while stalling upstream.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int ALUOP_W  = 2,
  parameter int OPCODE_W = 4,
  parameter int CTRL_W   = 4,
  parameter int MUL_LAT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  alu_op,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   control,
  output logic                multi_cycle,
  output logic                illegal,
  output logic                busy
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CTRL_W-1:0]  dec_code;
  logic               dec_mul;
  logic               dec_ill;
  logic               accept;
  logic               go_busy;

  alu_ctrl_decode #(
    .ALUOP_W  (ALUOP_W),
    .OPCODE_W (OPCODE_W),
    .CTRL_W   (CTRL_W)
  ) u_decode (
    .alu_op      (alu_op),
    .opcode      (opcode),
    .code        (dec_code),
    .multi_cycle (dec_mul),
    .illegal     (dec_ill)
  );

  // rst_n gates in_ready so nothing is offered as accepted while in reset
  assign in_ready = rst_n && !flush &&
                    ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign go_busy  = dec_mul && (MUL_LAT > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      control     <= '0;
      out_valid   <= 1'b0;
      multi_cycle <= 1'b0;
      illegal     <= 1'b0;
      busy        <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      multi_cycle <= 1'b0;
      illegal     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          if (cnt == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            multi_cycle <= 1'b0;
            illegal     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // A new op overrides the DONE->IDLE drain in the same cycle
      if (accept) begin
        control     <= dec_code;
        multi_cycle <= dec_mul;
        illegal     <= dec_ill;
        if (go_busy) begin
          state     <= BUSY;
          busy      <= 1'b1;
          out_valid <= 1'b0;
          cnt       <= CNT_LOAD;
        end else begin
          state     <= DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Random + directed check of alu_ctrl_seq (MUL_LAT=4 and MUL_LAT=1 instances)
// against a cycle-count behavioural model.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [1:0] alu_op;
  logic [3:0] opcode;
  logic       out_ready;

  logic       ir [2];
  logic       ov [2];
  logic [3:0] ctl [2];
  logic       mc [2];
  logic       ill [2];
  logic       bsy [2];

  int n_chk;
  int n_pass;

  // model: an op is pending, visible once m_rem busy cycles have elapsed
  bit       m_pend [2];
  int       m_rem  [2];
  int       m_ctl  [2];
  bit       m_mc   [2];
  bit       m_ill  [2];
  int       lat    [2];

  alu_ctrl_seq #(.ALUOP_W(2), .OPCODE_W(4), .CTRL_W(4), .MUL_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .alu_op(alu_op), .opcode(opcode), .out_valid(ov[0]), .out_ready(out_ready),
    .control(ctl[0]), .multi_cycle(mc[0]), .illegal(ill[0]), .busy(bsy[0])
  );

  alu_ctrl_seq #(.ALUOP_W(2), .OPCODE_W(4), .CTRL_W(4), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .alu_op(alu_op), .opcode(opcode), .out_valid(ov[1]), .out_ready(out_ready),
    .control(ctl[1]), .multi_cycle(mc[1]), .illegal(ill[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void ref_decode(input int aop, input int opc,
                                     output int code, output bit mul, output bit bad);
    mul = 1'b0;
    bad = 1'b0;
    code = 0;
    if (aop == 2) code = 1;
    else if (aop == 1) code = 0;
    else if (aop == 3) bad = 1'b1;
    else begin
      case (opc)
        2, 3: code = 0;
        4:    code = 1;
        5:    code = 2;
        6:    code = 3;
        7:    code = 4;
        8:    code = 5;
        9:    code = 6;
        10: begin code = 7; mul = 1'b1; end
        11:   code = 8;
        default: bad = 1'b1;
      endcase
    end
  endfunction

  function automatic bit exp_ir(input int i);
    return rst_n && !flush && (!m_pend[i] || (m_rem[i] == 0 && out_ready));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_rem[i] = 0; m_ctl[i] = 0; m_mc[i] = 0; m_ill[i] = 0;
    end
  endtask

  task automatic model_step();
    int code;
    bit mul, bad, acc;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pend[i] = 0; m_rem[i] = 0; m_ctl[i] = 0; m_mc[i] = 0; m_ill[i] = 0;
      end else if (flush) begin
        m_pend[i] = 0; m_rem[i] = 0; m_mc[i] = 0; m_ill[i] = 0;
      end else begin
        acc = in_valid && exp_ir(i);
        if (m_pend[i] && m_rem[i] > 0) m_rem[i]--;
        else if (m_pend[i] && out_ready) begin
          m_pend[i] = 0; m_mc[i] = 0; m_ill[i] = 0;
        end
        if (acc) begin
          ref_decode(alu_op, opcode, code, mul, bad);
          m_pend[i] = 1;
          m_rem[i]  = mul ? lat[i] - 1 : 0;
          m_ctl[i]  = code;
          m_mc[i]   = mul;
          m_ill[i]  = bad;
        end
      end
    end
  endtask

  task automatic compare_all();
    bit v;
    for (int i = 0; i < 2; i++) begin
      v = m_pend[i] && m_rem[i] == 0;
      chk($sformatf("out_valid[%0d]", i), ov[i], v);
      chk($sformatf("busy[%0d]", i), bsy[i], m_pend[i] && m_rem[i] > 0);
      chk($sformatf("in_ready[%0d]", i), ir[i], exp_ir(i));
      if (v) begin
        chk($sformatf("control[%0d]", i), ctl[i], m_ctl[i]);
        chk($sformatf("multi_cycle[%0d]", i), mc[i], m_mc[i]);
        chk($sformatf("illegal[%0d]", i), ill[i], m_ill[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input int aop, input int opc, input bit ordy);
    in_valid  = v;
    alu_op    = 2'(aop);
    opcode    = 4'(opc);
    out_ready = ordy;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ov"}, ov[i], 0);
      chk({tag, "_busy"}, bsy[i], 0);
      chk({tag, "_ir"}, ir[i], 0);
      chk({tag, "_ctl"}, ctl[i], 0);
      chk({tag, "_mc"}, mc[i], 0);
      chk({tag, "_ill"}, ill[i], 0);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    lat[0] = 4; lat[1] = 1;
    rst_n = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    tick();
    tick();
    chk_all_zero("reset");

    // first op after reset: SLL
    rst_n = 1'b1;
    drive(1, 0, 6, 1);
    #1;
    chk("ir_after_reset", ir[0], 1);
    tick();
    chk("sll_ov", ov[0], 1);
    chk("sll_ctl", ctl[0], 3);

    // back-to-back AND, OR, XOR
    drive(1, 0, 8, 1);
    tick();
    chk("and_ctl", ctl[0], 5);
    chk("and_ir", ir[0], 1);
    drive(1, 0, 9, 1);
    tick();
    chk("or_ctl", ctl[0], 6);
    chk("or_ir", ir[0], 1);
    drive(1, 0, 11, 1);
    tick();
    chk("xor_ctl", ctl[0], 8);
    chk("xor_ov", ov[0], 1);
    drive(0, 0, 0, 1);
    tick();

    // MUL: latency 4 on dut4, 1 on dut1
    drive(1, 0, 10, 1);
    tick();
    chk("mul_c1_busy", bsy[0], 1);
    chk("mul_c1_ir", ir[0], 0);
    chk("mul1_ov", ov[1], 1);
    chk("mul1_ctl", ctl[1], 7);
    chk("mul1_mc", mc[1], 1);
    chk("mul1_busy", bsy[1], 0);
    drive(0, 0, 0, 1);
    tick();
    chk("mul_c2_busy", bsy[0], 1);
    tick();
    chk("mul_c3_busy", bsy[0], 1);
    chk("mul_c3_ov", ov[0], 0);
    tick();
    chk("mul_c4_ov", ov[0], 1);
    chk("mul_c4_ctl", ctl[0], 7);
    chk("mul_c4_mc", mc[0], 1);
    chk("mul_c4_busy", bsy[0], 0);
    tick();

    // backpressure on SUB, then NOT accepted on release
    drive(1, 0, 4, 0);
    tick();
    chk("bp_ctl0", ctl[0], 1);
    drive(1, 0, 5, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_ctl", ctl[0], 1);
      chk("bp_hold_ov", ov[0], 1);
      chk("bp_hold_ir", ir[0], 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ir", ir[0], 1);
    tick();
    chk("not_ctl", ctl[0], 2);
    drive(0, 0, 0, 1);
    tick();

    // illegal / branch classes
    drive(1, 3, 0, 1);
    tick();
    chk("aop11_ctl", ctl[0], 0);
    chk("aop11_ill", ill[0], 1);
    drive(1, 2, 15, 1);
    tick();
    chk("aop10_ctl", ctl[0], 1);
    chk("aop10_ill", ill[0], 0);
    drive(1, 0, 15, 1);
    tick();
    chk("op1111_ctl", ctl[0], 0);
    chk("op1111_ill", ill[0], 1);
    drive(0, 0, 0, 1);
    tick();

    // flush during BUSY cycle 2
    drive(1, 0, 10, 1);
    tick();
    drive(0, 0, 0, 1);
    tick();
    chk("fl_busy", bsy[0], 1);
    flush = 1'b1;
    #1;
    chk("fl_ir", ir[0], 0);
    tick();
    flush = 1'b0;
    chk("fl_ov", ov[0], 0);
    chk("fl_busy_clr", bsy[0], 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fl_no_ov", ov[0], 0);
    end

    // flush coincident with in_valid drops the op
    flush = 1'b1;
    drive(1, 0, 6, 1);
    tick();
    chk("fl_drop_ov", ov[0], 0);
    flush = 1'b0;
    drive(0, 0, 0, 1);
    tick();
    chk("fl_drop_ov2", ov[0], 0);

    // reset mid-MUL
    drive(1, 0, 10, 1);
    tick();
    drive(0, 0, 0, 1);
    tick();
    chk("rst_busy", bsy[0], 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      alu_op    = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      opcode    = ($urandom_range(0, 2) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
